// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, sequencer state encoding, step codes and step lookup
// shared by the ALU internal-mode sequencer and the step encoder.
package alu_ctrl_pkg;
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_MOV     = 3'd1;
  localparam logic [2:0] OP_INC     = 3'd2;
  localparam logic [2:0] OP_DEC     = 3'd3;
  localparam logic [2:0] OP_POSTINC = 3'd4;
  localparam logic [2:0] OP_POSTDEC = 3'd5;
  localparam logic [2:0] OP_PREDEC  = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_STEP1, S_STEP2, S_FIN} state_t;
  typedef enum logic [2:0] {STEP_NONE, STEP_MOV, STEP_INC, STEP_DEC} step_t;
  // Step performed by an opcode while the sequencer sits in state s.
  function automatic step_t step_code(state_t s, logic [2:0] op);
    if (s == S_STEP1)
      return (op == OP_INC) ? STEP_INC :
             (op == OP_DEC || op == OP_PREDEC) ? STEP_DEC :
             (op == OP_MOV || op == OP_POSTINC || op == OP_POSTDEC) ? STEP_MOV : STEP_NONE;
    if (s == S_STEP2)
      return (op == OP_POSTINC) ? STEP_INC :
             (op == OP_POSTDEC) ? STEP_DEC :
             (op == OP_PREDEC) ? STEP_MOV : STEP_NONE;
    return STEP_NONE;
  endfunction
endpackage

// File: rtl/alu_step_encode.sv
// alu_step_encode: maps a step code and address-mode bit to the active-low
// internal-mode strobes.
//   step           in  step code (STEP_NONE releases every strobe)
//   addr           in  address-calculation mode
//   mov_n, addr_mode_n, inc_dec_n, dec_n  out  active-low strobes
module alu_step_encode
  import alu_ctrl_pkg::*;
(
  input  step_t step,
  input  logic  addr,
  output logic  mov_n,
  output logic  addr_mode_n,
  output logic  inc_dec_n,
  output logic  dec_n
);
  always_comb begin
    mov_n       = step == STEP_NONE;
    addr_mode_n = step == STEP_NONE || !addr;
    inc_dec_n   = !(step == STEP_INC || step == STEP_DEC);
    dec_n       = step != STEP_DEC;
  end
endmodule

// File: rtl/alu_internal_seq.sv
// alu_internal_seq: sequences ALU internal-mode strobes for single/two-step
// register-modify operations with HOLD stall and hold watchdog.
//   CLK, RST_N                       clock, async active-low reset
//   REQ_VALID/REQ_READY/REQ_OP/REQ_ADDR  request handshake, opcode, addr mode
//   HOLD                             stall; freezes the current step
//   INTERNAL_MOV_N, ADDRESS_MODE_N, INTERNAL_INC_DEC_N, INTERNAL_DEC_N
//                                    registered active-low strobes
//   DONE, ABORT                      one-cycle completion / abort pulses
// Build option: ALU_SEQ_ILLEGAL_TRAP_EN makes opcode 7 abort instead of
// completing as a NOP.
module alu_internal_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W       = 3,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [OP_W-1:0] REQ_OP,
  input  logic            REQ_ADDR,
  input  logic            HOLD,
  output logic            INTERNAL_MOV_N,
  output logic            ADDRESS_MODE_N,
  output logic            INTERNAL_INC_DEC_N,
  output logic            INTERNAL_DEC_N,
  output logic            DONE,
  output logic            ABORT
);
  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             addr_q, addr_d, ready_q, accept, in_step, fire, trap, two_step;
  logic             mov_d, am_d, id_d, dec_d;
  step_t            step_d;
  // ready_q keeps REQ_READY low while reset is asserted and until the first clock after release.
  assign REQ_READY = ready_q && (state_q == S_IDLE || state_q == S_FIN);
  assign accept    = REQ_VALID && REQ_READY;
  assign in_step   = state_q == S_STEP1 || state_q == S_STEP2;
  assign fire      = in_step && HOLD && cnt_q == CNT_W'(WAIT_LIMIT);
  assign two_step  = op_q == OP_W'(OP_POSTINC) || op_q == OP_W'(OP_POSTDEC) || op_q == OP_W'(OP_PREDEC);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign trap = accept && REQ_OP == OP_W'(OP_ILLEGAL);
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    op_d    = accept ? REQ_OP : op_q;
    addr_d  = accept ? REQ_ADDR : addr_q;
    if (!in_step)
      state_d = (!accept || trap) ? S_IDLE :
                (REQ_OP == OP_W'(OP_NOP) || REQ_OP == OP_W'(OP_ILLEGAL)) ? S_FIN : S_STEP1;
    else if (HOLD) begin
      state_d = fire ? S_IDLE : state_q;
      cnt_d   = fire ? '0 : cnt_q + CNT_W'(1);
    end else
      state_d = (state_q == S_STEP1 && two_step) ? S_STEP2 : S_FIN;
    step_d = step_code(state_d, op_d[2:0]);
  end
  // Strobes are encoded from the next state so the registered outputs line up with the state.
  alu_step_encode u_enc (
    .step        (step_d),
    .addr        (addr_d),
    .mov_n       (mov_d),
    .addr_mode_n (am_d),
    .inc_dec_n   (id_d),
    .dec_n       (dec_d)
  );
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q            <= S_IDLE;
      op_q               <= '0;
      addr_q             <= 1'b0;
      cnt_q              <= '0;
      ready_q            <= 1'b0;
      INTERNAL_MOV_N     <= 1'b1;
      ADDRESS_MODE_N     <= 1'b1;
      INTERNAL_INC_DEC_N <= 1'b1;
      INTERNAL_DEC_N     <= 1'b1;
      DONE               <= 1'b0;
      ABORT              <= 1'b0;
    end else begin
      state_q            <= state_d;
      op_q               <= op_d;
      addr_q             <= addr_d;
      cnt_q              <= cnt_d;
      ready_q            <= 1'b1;
      INTERNAL_MOV_N     <= mov_d;
      ADDRESS_MODE_N     <= am_d;
      INTERNAL_INC_DEC_N <= id_d;
      INTERNAL_DEC_N     <= dec_d;
      DONE               <= state_d == S_FIN;
      ABORT              <= fire || trap;
    end
  end
endmodule

// File: tb/tb_alu_internal_seq.sv
// tb_alu_internal_seq: directed scoreboard bench for alu_internal_seq.
module tb_alu_internal_seq;
  import alu_ctrl_pkg::*;
  localparam int K_IDLE = 0, K_MOV = 1, K_INC = 2, K_DEC = 3, K_FIN = 4, K_ABT = 5;
  logic       CLK = 1'b0, RST_N = 1'b0, REQ_VALID = 1'b0, REQ_ADDR = 1'b0, HOLD = 1'b0;
  logic [2:0] REQ_OP = 3'd0;
  logic       REQ_READY, INTERNAL_MOV_N, ADDRESS_MODE_N, INTERNAL_INC_DEC_N, INTERNAL_DEC_N, DONE, ABORT;
  logic [6:0] obs;
  logic [6:0] sb_q[$];
  string      tag_q[$];
  int         ncmp = 0, nfail = 0;
  alu_internal_seq dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .REQ_VALID          (REQ_VALID),
    .REQ_READY          (REQ_READY),
    .REQ_OP             (REQ_OP),
    .REQ_ADDR           (REQ_ADDR),
    .HOLD               (HOLD),
    .INTERNAL_MOV_N     (INTERNAL_MOV_N),
    .ADDRESS_MODE_N     (ADDRESS_MODE_N),
    .INTERNAL_INC_DEC_N (INTERNAL_INC_DEC_N),
    .INTERNAL_DEC_N     (INTERNAL_DEC_N),
    .DONE               (DONE),
    .ABORT              (ABORT)
  );
  always #5 CLK = ~CLK;
  // {ready, mov_n, addr_mode_n, inc_dec_n, dec_n, done, abort}
  assign obs = {REQ_READY, INTERNAL_MOV_N, ADDRESS_MODE_N, INTERNAL_INC_DEC_N, INTERNAL_DEC_N, DONE, ABORT};
  function automatic logic [6:0] ev(int k, logic a);
    case (k)
      K_MOV:   return {1'b0, 1'b0, ~a, 1'b1, 1'b1, 1'b0, 1'b0};
      K_INC:   return {1'b0, 1'b0, ~a, 1'b0, 1'b1, 1'b0, 1'b0};
      K_DEC:   return {1'b0, 1'b0, ~a, 1'b0, 1'b0, 1'b0, 1'b0};
      K_FIN:   return 7'b1111110;
      K_ABT:   return 7'b1111101;
      default: return 7'b1111100;
    endcase
  endfunction
  task automatic check(string tag, logic [6:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic push(string tag, int k, logic a, int n = 1);
    repeat (n) begin
      sb_q.push_back(ev(k, a));
      tag_q.push_back(tag);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      ncmp++;
      nfail++;
      $error("FAIL sb_empty observed=%b expected=<queued entry>", obs);
    end else
      check(tag_q.pop_front(), sb_q.pop_front());
  endtask
  task automatic drain();
    while (sb_q.size() > 0) cyc();
  endtask
  task automatic req(logic [2:0] op, logic a);
    REQ_VALID = 1'b1;
    REQ_OP    = op;
    REQ_ADDR  = a;
  endtask
  initial begin
    #12 check("reset_low", 7'b0111100);
    @(negedge CLK) RST_N = 1'b1;
    push("reset_release", K_IDLE, 0);
    cyc();
    req(OP_POSTDEC, 1);
    push("postdec_s1", K_MOV, 1); push("postdec_s2", K_DEC, 1);
    push("postdec_fin", K_FIN, 0); push("postdec_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; drain();
    req(OP_MOV, 0); push("mov", K_MOV, 0); push("mov_fin", K_FIN, 0); push("mov_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; drain();
    req(OP_INC, 1); push("inc", K_INC, 1); push("inc_fin", K_FIN, 0); push("inc_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; drain();
    req(OP_DEC, 0); push("dec", K_DEC, 0); push("dec_fin", K_FIN, 0); push("dec_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; drain();
    req(OP_NOP, 1); push("nop_fin", K_FIN, 0); push("nop_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; drain();
    req(OP_MOV, 0);
    push("b2b_mov", K_MOV, 0); push("b2b_fin1", K_FIN, 0); push("b2b_inc", K_INC, 0);
    push("b2b_fin2", K_FIN, 0); push("b2b_idle", K_IDLE, 0);
    cyc(); REQ_OP = OP_INC; cyc(); cyc(); REQ_VALID = 1'b0; drain();
    req(OP_PREDEC, 1);
    push("predec_hold_dec", K_DEC, 1, 4); push("predec_mov", K_MOV, 1);
    push("predec_fin", K_FIN, 0); push("predec_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; HOLD = 1'b1; repeat (3) cyc(); HOLD = 1'b0; drain();
    req(OP_POSTINC, 0);
    push("hold_lim_s1", K_MOV, 0, 16); push("hold_lim_s2", K_INC, 0, 16);
    push("hold_lim_fin", K_FIN, 0); push("hold_lim_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; HOLD = 1'b1; repeat (15) cyc();
    HOLD = 1'b0; cyc(); HOLD = 1'b1; repeat (15) cyc(); HOLD = 1'b0; drain();
    req(OP_POSTINC, 1);
    push("wdog_s1", K_MOV, 1, 16); push("wdog_abort", K_ABT, 0); push("wdog_idle", K_IDLE, 0, 2);
    cyc(); REQ_VALID = 1'b0; HOLD = 1'b1; drain(); HOLD = 1'b0;
    req(OP_ILLEGAL, 0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    push("op7_abort", K_ABT, 0);
`else
    push("op7_fin", K_FIN, 0);
`endif
    push("op7_idle", K_IDLE, 0);
    cyc(); REQ_VALID = 1'b0; drain();
    req(OP_POSTINC, 0); push("rst_seq_s1", K_MOV, 0); push("rst_seq_s2", K_INC, 0);
    cyc(); REQ_VALID = 1'b0; cyc();
    #2 RST_N = 1'b0;
    #1 check("async_reset", 7'b0111100);
    @(negedge CLK) RST_N = 1'b1;
    push("post_reset_idle", K_IDLE, 0, 2);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/alu_internal_seq.md
Name: alu_internal_seq

Overview:
- Sequences the ALU control decoder's active-low internal-mode strobes (INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC) for single- and two-step register-modify operations: MOV, INC, DEC, post-inc/dec and pre-dec.
- Sits between the instruction control unit, which issues a valid/ready request, and the Ctrl1..CtrlN decoders, which consume the strobes.
- A HOLD input freezes the current step. A watchdog aborts a step held for too long.

Parameters:
- OP_W, 3, request opcode width.
- WAIT_LIMIT, 15, maximum consecutive HOLD cycles in one step before abort.
- CNT_W, 4, hold-counter width. Must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_OP  in  OP_W  opcode: 0 NOP, 1 MOV, 2 INC, 3 DEC, 4 POSTINC, 5 POSTDEC, 6 PREDEC, 7 illegal.
- REQ_ADDR  in  1  address-calculation mode for the whole sequence.
- HOLD  in  1  ALU/memory stall; freezes the current step.
- INTERNAL_MOV_N  out  1  active-low.
- ADDRESS_MODE_N  out  1  active-low.
- INTERNAL_INC_DEC_N  out  1  active-low.
- INTERNAL_DEC_N  out  1  active-low.
- DONE  out  1  one-cycle pulse when a sequence completes.
- ABORT  out  1  one-cycle pulse when the hold watchdog fires.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE.
  - All *_N outputs = 1.
  - REQ_READY=0 while RST_N is low, 1 from the first clock after release.
  - DONE=0, ABORT=0, hold counter = 0.
  - Reset mid-sequence drops the operation silently; no DONE is produced.
- States: IDLE, STEP1, STEP2, FIN.
- All strobe outputs and DONE/ABORT are registered; none are combinational from inputs.
- REQ_READY = (state==IDLE) or (state==FIN).
- Acceptance is REQ_VALID & REQ_READY at a rising edge. The sequencer latches REQ_OP and REQ_ADDR at that edge.
- Step encodings (*_N values):
  - MOV: MOV_N=0, INC_DEC_N=1, DEC_N=1.
  - INC: MOV_N=0, INC_DEC_N=0, DEC_N=1.
  - DEC: MOV_N=0, INC_DEC_N=0, DEC_N=0.
  - ADDRESS_MODE_N = ~latched REQ_ADDR during STEP1 and STEP2. It is 1 otherwise.
- Sequences:
  - MOV, INC, DEC: STEP1 only.
  - POSTINC: STEP1=MOV, then STEP2=INC.
  - POSTDEC: STEP1=MOV, then STEP2=DEC.
  - PREDEC: STEP1=DEC, then STEP2=MOV.
- Timing for a sequence accepted at edge N:
  - STEP1 strobes are visible from N+1.
  - Without HOLD, STEP2 strobes are visible from N+2 (two-step ops).
  - FIN is entered after the last step. DONE=1 and all *_N=1 in FIN.
  - FIN lasts one cycle. A request accepted in FIN starts STEP1 on the next cycle, giving back-to-back operation with one idle strobe cycle.
- NOP: accepted, goes directly to FIN, so DONE pulses at N+1. No strobes are asserted.
- HOLD:
  - Sampled in STEP1/STEP2. With HOLD=1 the state and strobes stay unchanged and the hold counter increments.
  - The counter clears on every step advance.
  - HOLD is ignored in IDLE and FIN.
- Watchdog:
  - If HOLD=1 while the counter equals WAIT_LIMIT, the next state is IDLE.
  - All *_N go to 1, ABORT=1 for one cycle, and DONE is not asserted.
- Illegal opcode (7): see Optional Feature.

Optional Feature:
- Macro: ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: opcode 7 is accepted and goes directly to IDLE with ABORT=1 for one cycle. No strobes, no DONE.
- Undefined: opcode 7 is treated exactly as NOP (DONE via FIN). The ABORT port remains present and is driven only by the watchdog.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - the opcode localparams (OP_NOP..OP_ILLEGAL);
  - the state encoding;
  - a 3-bit step-code type (STEP_NONE, STEP_MOV, STEP_INC, STEP_DEC).
- One natural sub-module, alu_step_encode: combinational mapping from step code and addr bit to the four *_N values.
  - It is shared with future decoders.
  - Its outputs are registered in alu_internal_seq.

Test Plan:
- Reset then idle: RST_N low mid-POSTINC at STEP2 -> all *_N=1 immediately (asynchronously). After release, REQ_READY=1 and no DONE.
- POSTDEC, REQ_ADDR=1, HOLD=0, accepted at cycle 0:
  - cycle 1: MOV_N=0, ADDRESS_MODE_N=0, INC_DEC_N=1, DEC_N=1.
  - cycle 2: MOV_N=0, INC_DEC_N=0, DEC_N=0, ADDRESS_MODE_N=0.
  - cycle 3: DONE=1, all *_N=1.
- Back-to-back: INC accepted in the FIN cycle of the previous op -> INC strobes two cycles after the previous last step. Exactly one DONE per op.
- HOLD=1 for 3 cycles in STEP1 of PREDEC -> DEC strobes persist 4 cycles, then MOV for 1 cycle, then DONE.
- Watchdog: HOLD held for 17 cycles in STEP1 with WAIT_LIMIT=15 -> ABORT=1 on the 17th cycle after entering STEP1, all *_N=1, back in IDLE, no DONE.
- Opcode 7:
  - With ALU_SEQ_ILLEGAL_TRAP_EN defined -> ABORT pulse at N+1, no DONE.
  - Without it -> DONE at N+1, no ABORT.
